// File: rtl/pin_ctrl_pkg.sv
// Shared types and key encodings for the PIN entry sequencer.
package pin_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_FULL,
        ST_CHECK,
        ST_WAIT,
        ST_UNLOCKED,
        ST_LOCKOUT
    } state_t;

    localparam logic [3:0] KEY_CLEAR     = 4'hA;
    localparam logic [3:0] KEY_ENTER     = 4'hB;
    localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= KEY_DIGIT_MAX;
    endfunction

endpackage

// File: rtl/pin_ctrl_timer.sv
// Loadable down-counter with a zero flag; shared by every timed wait of the sequencer.
module pin_ctrl_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] load_value,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pin_entry_controller.sv
// Keypad sequencer in front of the PIN checker: entry, request, verdict, unlock and lockout.
// Define PIN_CTRL_INACTIVITY_TIMEOUT_EN to discard partial entries after ENTRY_TIMEOUT idle cycles.
module pin_entry_controller
    import pin_ctrl_pkg::*;
#(
    parameter int MAX_ATTEMPTS    = 3,
    parameter int LOCKOUT_CYCLES  = 100,
    parameter int VERDICT_TIMEOUT = 16,
    parameter int ENTRY_TIMEOUT   = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    output logic [15:0] pin_out,
    output logic        check_req,
    input  logic        granted_in,
    input  logic        denied_in,
    input  logic        relock,
    output logic        unlocked,
    output logic        locked_out,
    output logic [2:0]  fail_count,
    output logic [2:0]  digit_count
);

    localparam int T_MAX_A = (LOCKOUT_CYCLES > VERDICT_TIMEOUT) ? LOCKOUT_CYCLES : VERDICT_TIMEOUT;
    localparam int T_MAX   = (T_MAX_A > ENTRY_TIMEOUT) ? T_MAX_A : ENTRY_TIMEOUT;
    localparam int TIMER_W = $clog2(T_MAX + 1);
    localparam logic [2:0] MAX_FAIL = 3'(MAX_ATTEMPTS);

    state_t               state;
    logic                 key_accept;
    logic                 verdict_grant;
    logic                 verdict_deny;
    logic                 entry_expired;
    logic [2:0]           fail_next;
    logic                 timer_load;
    logic                 timer_enable;
    logic [TIMER_W-1:0]   timer_value;
    logic                 timer_zero;

    assign key_accept = key_valid
                     && (state == ST_IDLE || state == ST_ENTRY || state == ST_FULL)
                     && (is_digit(key_code) || key_code == KEY_CLEAR || key_code == KEY_ENTER);

    // Both verdict lines high is treated as a denial (fail-safe).
    assign verdict_grant = granted_in && !denied_in;
    assign verdict_deny  = denied_in || (!granted_in && timer_zero);
    assign fail_next     = (fail_count < MAX_FAIL) ? fail_count + 3'd1 : fail_count;

`ifdef PIN_CTRL_INACTIVITY_TIMEOUT_EN
    assign entry_expired = (state == ST_ENTRY || state == ST_FULL) && !key_accept && timer_zero;
`else
    assign entry_expired = 1'b0;
`endif

    // Loads are set up one cycle ahead so the zero flag lands on the terminal edge.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves it unassigned and no latch is inferred.
        timer_load   = 1'b0;
        timer_enable = 1'b0;
        timer_value  = '0;
        if (key_accept) begin
            timer_load  = 1'b1;
            timer_value = TIMER_W'(ENTRY_TIMEOUT - 1);
        end else begin
            case (state)
                ST_CHECK: begin
                    timer_load  = 1'b1;
                    timer_value = TIMER_W'(VERDICT_TIMEOUT - 1);
                end
                ST_WAIT: begin
                    if (verdict_deny && fail_next == MAX_FAIL) begin
                        timer_load  = 1'b1;
                        timer_value = TIMER_W'(LOCKOUT_CYCLES - 1);
                    end else begin
                        timer_enable = 1'b1;
                    end
                end
                ST_LOCKOUT: timer_enable = 1'b1;
`ifdef PIN_CTRL_INACTIVITY_TIMEOUT_EN
                ST_ENTRY, ST_FULL: timer_enable = 1'b1;
`endif
                default: timer_enable = 1'b0;
            endcase
        end
    end

    pin_ctrl_timer #(.WIDTH(TIMER_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .enable     (timer_enable),
        .load_value (timer_value),
        .zero       (timer_zero)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            pin_out     <= 16'h0000;
            check_req   <= 1'b0;
            unlocked    <= 1'b0;
            locked_out  <= 1'b0;
            fail_count  <= 3'd0;
            digit_count <= 3'd0;
        end else begin
            check_req <= 1'b0;
            case (state)
                ST_IDLE, ST_ENTRY, ST_FULL: begin
                    if (key_accept) begin
                        if (key_code == KEY_CLEAR) begin
                            pin_out     <= 16'h0000;
                            digit_count <= 3'd0;
                            state       <= ST_IDLE;
                        end else if (key_code == KEY_ENTER) begin
                            if (state == ST_FULL) begin
                                state     <= ST_CHECK;
                                check_req <= 1'b1;
                            end
                        end else if (digit_count < 3'd4) begin
                            pin_out     <= {pin_out[11:0], key_code};
                            digit_count <= digit_count + 3'd1;
                            state       <= (digit_count == 3'd3) ? ST_FULL : ST_ENTRY;
                        end
                    end else if (entry_expired) begin
                        pin_out     <= 16'h0000;
                        digit_count <= 3'd0;
                        state       <= ST_IDLE;
                    end
                end
                ST_CHECK: state <= ST_WAIT;
                ST_WAIT: begin
                    if (verdict_grant) begin
                        state      <= ST_UNLOCKED;
                        unlocked   <= 1'b1;
                        fail_count <= 3'd0;
                    end else if (verdict_deny) begin
                        fail_count  <= fail_next;
                        pin_out     <= 16'h0000;
                        digit_count <= 3'd0;
                        if (fail_next == MAX_FAIL) begin
                            state      <= ST_LOCKOUT;
                            locked_out <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_UNLOCKED: begin
                    if (relock) begin
                        state       <= ST_IDLE;
                        unlocked    <= 1'b0;
                        pin_out     <= 16'h0000;
                        digit_count <= 3'd0;
                    end
                end
                ST_LOCKOUT: begin
                    if (timer_zero) begin
                        state      <= ST_IDLE;
                        locked_out <= 1'b0;
                        fail_count <= 3'd0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pin_entry_controller.sv
// Randomized bench for pin_entry_controller: queue-based buffer model plus a check_req scoreboard monitor.
module tb_pin_entry_controller;

    localparam int MAX_ATTEMPTS    = 3;
    localparam int LOCKOUT_CYCLES  = 100;
    localparam int VERDICT_TIMEOUT = 16;
    localparam int ENTRY_TIMEOUT   = 50;
    localparam logic [3:0] K_CLEAR = 4'hA;
    localparam logic [3:0] K_ENTER = 4'hB;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        key_valid = 1'b0;
    logic [3:0]  key_code = 4'h0;
    logic        granted_in = 1'b0;
    logic        denied_in = 1'b0;
    logic        relock = 1'b0;
    logic [15:0] pin_out;
    logic        check_req;
    logic        unlocked;
    logic        locked_out;
    logic [2:0]  fail_count;
    logic [2:0]  digit_count;

    pin_entry_controller #(
        .MAX_ATTEMPTS    (MAX_ATTEMPTS),
        .LOCKOUT_CYCLES  (LOCKOUT_CYCLES),
        .VERDICT_TIMEOUT (VERDICT_TIMEOUT),
        .ENTRY_TIMEOUT   (ENTRY_TIMEOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .pin_out     (pin_out),
        .check_req   (check_req),
        .granted_in  (granted_in),
        .denied_in   (denied_in),
        .relock      (relock),
        .unlocked    (unlocked),
        .locked_out  (locked_out),
        .fail_count  (fail_count),
        .digit_count (digit_count)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: buffered digits as a queue, failure tally, unlocked flag.
    int buf_q[$];
    int exp_pins[$];
    int m_fail = 0;
    bit m_unlocked = 1'b0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic int model_pin();
        int p = 0;
        foreach (buf_q[i]) p = (p << 4) | buf_q[i];
        return p;
    endfunction

    // Scoreboard monitor: every check_req must match a queued PIN and last one cycle.
    logic prev_req = 1'b0;
    always @(negedge clk) begin
        if (prev_req) check("check_req_width", check_req, 0);
        if (check_req === 1'b1) begin
            if (exp_pins.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL check_req_unexpected: got request with pin_out %0h, expected none", pin_out);
            end else begin
                check("check_req_pin", pin_out, exp_pins.pop_front());
            end
        end
        prev_req = check_req;
    end

    task automatic press(input logic [3:0] code, input int gap = 0);
        bit exp_req = 1'b0;
        repeat (gap) @(negedge clk);
        if (!m_unlocked) begin
            if (code <= 4'h9) begin
                if (buf_q.size() < 4) buf_q.push_back(int'(code));
            end else if (code == K_CLEAR) begin
                buf_q.delete();
            end else if (code == K_ENTER && buf_q.size() == 4) begin
                exp_req = 1'b1;
                exp_pins.push_back(model_pin());
            end
        end
        @(negedge clk);
        key_valid  = 1'b1;
        key_code   = code;
        granted_in = ($urandom % 4 == 0);
        denied_in  = ($urandom % 4 == 0);
        @(negedge clk);
        key_valid  = 1'b0;
        granted_in = 1'b0;
        denied_in  = 1'b0;
        check("digit_count", digit_count, buf_q.size());
        check("pin_out", pin_out, model_pin());
        check("check_req_after_key", check_req, exp_req);
    endtask

    task automatic enter_pin(input logic [15:0] pin);
        for (int i = 0; i < 4; i++) press(pin[15-4*i -: 4], $urandom % 3);
        press(K_ENTER, $urandom % 3);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_pin_out", pin_out, 0);
        check("rst_check_req", check_req, 0);
        check("rst_unlocked", unlocked, 0);
        check("rst_locked_out", locked_out, 0);
        check("rst_fail_count", fail_count, 0);
        check("rst_digit_count", digit_count, 0);
        reset = 1'b0;
        buf_q.delete();
        m_fail = 0;
        m_unlocked = 1'b0;
    endtask

    task automatic run_lockout();
        int cnt = 1;
        key_valid = $urandom % 2;
        key_code  = 4'($urandom % 10);
        for (int i = 0; i < LOCKOUT_CYCLES + 20; i++) begin
            @(negedge clk);
            if (!locked_out) break;
            cnt++;
            if (cnt == LOCKOUT_CYCLES / 2) check("lockout_digit_count", digit_count, 0);
            key_valid = $urandom % 2;
            key_code  = 4'($urandom % 10);
        end
        key_valid = 1'b0;
        m_fail = 0;
        check("lockout_length", cnt, LOCKOUT_CYCLES);
        check("after_lockout_locked_out", locked_out, 0);
        check("after_lockout_fail_count", fail_count, 0);
        check("after_lockout_digit_count", digit_count, 0);
    endtask

    // kind: 0 grant, 1 deny, 2 both high, 3 no verdict (timeout).
    task automatic give_verdict(input int kind, input int delay, input bit finish_lockout);
        int pin = model_pin();
        if (kind == 3) begin
            repeat (VERDICT_TIMEOUT) begin
                @(negedge clk);
                check("wait_pin_stable", pin_out, pin);
            end
            check("timeout_not_early", fail_count, m_fail);
            @(negedge clk);
        end else begin
            repeat (1 + delay) begin
                @(negedge clk);
                check("wait_pin_stable", pin_out, pin);
            end
            granted_in = (kind == 0 || kind == 2);
            denied_in  = (kind == 1 || kind == 2);
            @(negedge clk);
            granted_in = 1'b0;
            denied_in  = 1'b0;
        end
        if (kind == 0) begin
            m_unlocked = 1'b1;
            m_fail = 0;
            check("grant_unlocked", unlocked, 1);
            check("grant_fail_count", fail_count, 0);
            check("grant_pin_out", pin_out, pin);
            check("grant_locked_out", locked_out, 0);
        end else begin
            if (m_fail < MAX_ATTEMPTS) m_fail++;
            buf_q.delete();
            check("deny_fail_count", fail_count, m_fail);
            check("deny_digit_count", digit_count, 0);
            check("deny_pin_out", pin_out, 0);
            check("deny_unlocked", unlocked, 0);
            check("deny_locked_out", locked_out, (m_fail == MAX_ATTEMPTS));
            if (m_fail == MAX_ATTEMPTS && finish_lockout) run_lockout();
        end
    endtask

    task automatic do_relock();
        @(negedge clk);
        relock = 1'b1;
        @(negedge clk);
        relock = 1'b0;
        m_unlocked = 1'b0;
        buf_q.delete();
        check("relock_unlocked", unlocked, 0);
        check("relock_pin_out", pin_out, 0);
        check("relock_digit_count", digit_count, 0);
    endtask

    task automatic attempt(input int kind);
        logic [15:0] pin = 16'h0;
        for (int i = 0; i < 4; i++) pin = (pin << 4) | 16'($urandom % 10);
        if ($urandom % 3 == 0) press(4'($urandom_range(12, 15)));
        if ($urandom % 3 == 0) begin
            press(4'($urandom % 10));
            press(4'($urandom % 10), 1);
            press(K_CLEAR);
        end
        if ($urandom % 4 == 0) begin
            for (int i = 0; i < 3; i++) press(4'($urandom % 10));
            press(K_ENTER);
            press(K_CLEAR, 2);
        end
        for (int i = 0; i < 4; i++) press(pin[15-4*i -: 4], $urandom % 4);
        if ($urandom % 3 == 0) press(4'($urandom % 10));
        press(K_ENTER, $urandom % 3);
        give_verdict(kind, $urandom % 6, 1'b1);
        if (m_unlocked) begin
            press(4'($urandom % 16));
            press(4'($urandom % 16));
            do_relock();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 300000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();

        // Grant path.
        enter_pin(16'h8642);
        give_verdict(0, 2, 1'b1);
        do_relock();

        // Editing: partial entry cleared, then a full PIN.
        press(4'h3);
        press(4'h8);
        press(K_CLEAR);
        enter_pin(16'h8642);
        give_verdict(0, 0, 1'b1);
        do_relock();

        // Early ENTER and a fifth digit while full.
        press(4'h1);
        press(4'h2);
        press(4'h3);
        press(K_ENTER);
        press(4'h4);
        press(4'h5);
        press(K_ENTER);
        give_verdict(1, 3, 1'b1);

        // Both verdicts high, then timeout; the third denial runs the full lockout.
        enter_pin(16'h8431);
        give_verdict(2, 1, 1'b1);
        enter_pin(16'h8431);
        give_verdict(3, 0, 1'b1);

        // Reset while waiting for a verdict.
        enter_pin(16'h1111);
        @(negedge clk);
        do_reset();

        // Reset in the middle of a lockout.
        for (int i = 0; i < MAX_ATTEMPTS; i++) begin
            enter_pin(16'h8431);
            give_verdict(1, 0, 1'b0);
        end
        repeat (10) @(negedge clk);
        check("mid_lockout_locked_out", locked_out, 1);
        do_reset();

        // Inactivity on a partial entry.
        press(4'h1);
        press(4'h2);
        repeat (ENTRY_TIMEOUT - 1) @(negedge clk);
        check("inactivity_not_early", digit_count, 2);
        @(negedge clk);
`ifdef PIN_CTRL_INACTIVITY_TIMEOUT_EN
        buf_q.delete();
`endif
        check("inactivity_digit_count", digit_count, buf_q.size());
        check("inactivity_fail_count", fail_count, m_fail);
        press(K_CLEAR);

        // Randomized attempts.
        for (int n = 0; n < 24; n++) attempt($urandom % 4);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_pins.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
